// File: rtl/cv32e40p_clock_gate_ctrl.sv
// Enable-side controller for the core clock gate.
// Runs on the free-running clock. It drains outstanding activity and waits
// through an idle hysteresis window before it gates the core clock. On wake it
// re-enables the clock and holds a settle window before it releases the core.
// Optional build macro: CV32E40P_CG_STATS_EN adds a saturating counter of
// gated cycles on gated_cycles_o. Without the macro that output is tied to 0.
module cv32e40p_clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sleep_req_i,
  input  logic        busy_i,
  input  logic        wake_i,
  input  logic        scan_cg_en_i,
  output logic        en_o,
  output logic        sleeping_o,
  output logic        wake_ack_o,
  output logic [31:0] gated_cycles_o
);

  localparam logic [2:0] S_RUN   = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_GATED = 3'd3;
  localparam logic [2:0] S_WAKE  = 3'd4;

  // Counter reload values. A zero parameter skips its state, so the reload
  // value is never used in that case.
  localparam logic [7:0] IDLE_LOAD = (IDLE_CYCLES > 0) ? 8'(IDLE_CYCLES - 1) : 8'd0;
  localparam logic [7:0] WAKE_LOAD = (WAKE_CYCLES > 0) ? 8'(WAKE_CYCLES - 1) : 8'd0;

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic       r_en_q;
  logic       r_sleeping;
  logic       r_wake_ack;

  logic [2:0] w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic       w_ack_nxt;

  // Next-state logic. wake_i has priority over sleep_req_i and busy_i everywhere.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (sleep_req_i && !wake_i) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (wake_i || !sleep_req_i) begin
          w_state_nxt = S_RUN;
        end else if (!busy_i) begin
          if (IDLE_CYCLES == 0) begin
            w_state_nxt = S_GATED;
          end else begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = IDLE_LOAD;
          end
        end
      end
      S_HOLD: begin
        if (wake_i || !sleep_req_i) begin
          w_state_nxt = S_RUN;
        end else if (busy_i) begin
          w_state_nxt = S_DRAIN;
        end else if (r_cnt == 8'd0) begin
          w_state_nxt = S_GATED;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_GATED: begin
        if (wake_i) begin
          if (WAKE_CYCLES == 0) begin
            w_state_nxt = S_RUN;
            w_ack_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_WAKE;
            w_cnt_nxt   = WAKE_LOAD;
          end
        end
      end
      S_WAKE: begin
        // A wake is never aborted once started, whatever wake_i does now.
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_RUN;
          w_ack_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // State and output flops. en_q changes only on the edge that enters or
  // leaves GATED, so the latch-based gate sees a clean, registered enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_RUN;
      r_cnt      <= 8'd0;
      r_en_q     <= 1'b1;
      r_sleeping <= 1'b0;
      r_wake_ack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_en_q     <= (w_state_nxt != S_GATED);
      r_sleeping <= (w_state_nxt == S_GATED) || (w_state_nxt == S_WAKE);
      r_wake_ack <= w_ack_nxt;
    end
  end

  // Scan mode forces the clock on without disturbing the state machine.
  assign en_o       = r_en_q | scan_cg_en_i;
  assign sleeping_o = r_sleeping;
  assign wake_ack_o = r_wake_ack;

`ifdef CV32E40P_CG_STATS_EN
  logic [31:0] r_gated_cycles;

  // Saturating count of edges spent in GATED; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gated_cycles <= 32'd0;
    end else if ((r_state == S_GATED) && (r_gated_cycles != 32'hFFFF_FFFF)) begin
      r_gated_cycles <= r_gated_cycles + 32'd1;
    end
  end

  assign gated_cycles_o = r_gated_cycles;
`else
  assign gated_cycles_o = 32'd0;
`endif

endmodule
